id_ex_stage: RTL

- ID/EX pipeline register for the five-stage RV32I core.
- Includes load-use hazard detection and bubble insertion.
- Captures decoded operands, register indices and control fields from ID. Presents them to EX, the forwarding unit (rs1_ex, rs2_ex) and the ALU operand muxes.
- Raises a one-cycle stall toward PC/IF-ID on a load-use hazard. Squashes its contents on a taken branch/jump from EX.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/load_use_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the ID/EX control bundle for the RV32I core.
// Used by id_ex_stage and load_use_detect.
package pipe_pkg;

    localparam logic [4:0] BR_NONE = 5'b00000;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef struct packed {
        logic       ru_wr;
        logic       alu_a_src;
        logic       alu_b_src;
        logic       dm_wr;
        logic [3:0] alu_op;
        logic [4:0] br_op;
        logic [2:0] dm_ctrl;
        logic [1:0] wb_src;
    } id_ex_ctrl_t;

    // A bubble must never write the register file or memory, and never branch.
    localparam id_ex_ctrl_t BUBBLE_CTRL = '{
        ru_wr:     1'b0,
        alu_a_src: 1'b0,
        alu_b_src: 1'b0,
        dm_wr:     1'b0,
        alu_op:    4'd0,
        br_op:     BR_NONE,
        dm_ctrl:   3'd0,
        wb_src:    WB_ALU
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction currently in ID.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              valid_ex_i,
    input  logic              ru_wr_ex_i,
    input  logic [1:0]        wb_src_ex_i,
    input  logic [REG_AW-1:0] rd_ex_i,
    input  logic [REG_AW-1:0] rs1_id_i,
    input  logic [REG_AW-1:0] rs2_id_i,
    input  logic              uses_rs1_id_i,
    input  logic              uses_rs2_id_i,
    output logic              load_use_o
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it can never create a dependency.
    assign ex_is_load = valid_ex_i && ru_wr_ex_i && (wb_src_ex_i == WB_MEM)
                        && (rd_ex_i != '0);
    assign rs1_hit    = uses_rs1_id_i && (rs1_id_i == rd_ex_i);
    assign rs2_hit    = uses_rs2_id_i && (rs2_id_i == rd_ex_i);
    assign load_use_o = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubble insertion.
// Optional stall/flush event counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [XLEN-1:0]   pc_id,
    input  logic [XLEN-1:0]   pc_plus4_id,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              uses_rs1_id,
    input  logic              uses_rs2_id,
    input  logic [XLEN-1:0]   ru_rs1_id,
    input  logic [XLEN-1:0]   ru_rs2_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic              valid_id,
    input  logic              RUWr_id,
    input  logic              ALUASrc_id,
    input  logic              ALUBSrc_id,
    input  logic              DMWr_id,
    input  logic [3:0]        ALUOp_id,
    input  logic [4:0]        BrOp_id,
    input  logic [2:0]        DMCtrl_id,
    input  logic [1:0]        RUDataWrSrc_id,
    input  logic              br_taken_ex,

    output logic [XLEN-1:0]   pc_ex,
    output logic [XLEN-1:0]   pc_plus4_ex,
    output logic [REG_AW-1:0] rs1_ex,
    output logic [REG_AW-1:0] rs2_ex,
    output logic [REG_AW-1:0] rd_ex,
    output logic              uses_rs1_ex,
    output logic              uses_rs2_ex,
    output logic [XLEN-1:0]   ru_rs1_ex,
    output logic [XLEN-1:0]   ru_rs2_ex,
    output logic [XLEN-1:0]   imm_ex,
    output logic              valid_ex,
    output logic              RUWr_ex,
    output logic              ALUASrc_ex,
    output logic              ALUBSrc_ex,
    output logic              DMWr_ex,
    output logic [3:0]        ALUOp_ex,
    output logic [4:0]        BrOp_ex,
    output logic [2:0]        DMCtrl_ex,
    output logic [1:0]        RUDataWrSrc_ex,
    output logic              stall_o,
    output logic              bubble_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    id_ex_ctrl_t       ctrl_id;
    id_ex_ctrl_t       ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [XLEN-1:0]   pc_d, pc_q;
    logic [XLEN-1:0]   pc_plus4_d, pc_plus4_q;
    logic [REG_AW-1:0] rs1_d, rs1_q;
    logic [REG_AW-1:0] rs2_d, rs2_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic              uses_rs1_d, uses_rs1_q;
    logic              uses_rs2_d, uses_rs2_q;
    logic [XLEN-1:0]   ru_rs1_d, ru_rs1_q;
    logic [XLEN-1:0]   ru_rs2_d, ru_rs2_q;
    logic [XLEN-1:0]   imm_d, imm_q;

    logic load_use;
    logic flush;
    logic take_bubble;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .valid_ex_i    (valid_q),
        .ru_wr_ex_i    (ctrl_q.ru_wr),
        .wb_src_ex_i   (ctrl_q.wb_src),
        .rd_ex_i       (rd_q),
        .rs1_id_i      (rs1_id),
        .rs2_id_i      (rs2_id),
        .uses_rs1_id_i (uses_rs1_id),
        .uses_rs2_id_i (uses_rs2_id),
        .load_use_o    (load_use)
    );

    // A wrong-path ID instruction is discarded, so a flush suppresses the stall.
    assign flush       = br_taken_ex;
    assign take_bubble = flush || load_use;
    assign stall_o     = load_use && !flush;
    assign bubble_o    = take_bubble;

    // Side-effecting controls of a non-instruction are neutralised at capture.
    always_comb begin
        ctrl_id = '{
            ru_wr:     RUWr_id && valid_id,
            alu_a_src: ALUASrc_id,
            alu_b_src: ALUBSrc_id,
            dm_wr:     DMWr_id && valid_id,
            alu_op:    ALUOp_id,
            br_op:     valid_id ? BrOp_id : BR_NONE,
            dm_ctrl:   DMCtrl_id,
            wb_src:    RUDataWrSrc_id
        };
    end

    always_comb begin
        // NOTE: every _d gets a value before the branch so no path leaves one unassigned (no latch).
        valid_d    = valid_id;
        ctrl_d     = ctrl_id;
        pc_d       = pc_id;
        pc_plus4_d = pc_plus4_id;
        rs1_d      = rs1_id;
        rs2_d      = rs2_id;
        rd_d       = rd_id;
        uses_rs1_d = uses_rs1_id;
        uses_rs2_d = uses_rs2_id;
        ru_rs1_d   = ru_rs1_id;
        ru_rs2_d   = ru_rs2_id;
        imm_d      = imm_id;
        if (take_bubble) begin
            // Zeroed indices keep the forwarding unit from matching a bubble.
            valid_d    = 1'b0;
            ctrl_d     = BUBBLE_CTRL;
            pc_d       = '0;
            pc_plus4_d = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            uses_rs1_d = 1'b0;
            uses_rs2_d = 1'b0;
            ru_rs1_d   = '0;
            ru_rs2_d   = '0;
            imm_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= BUBBLE_CTRL;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            uses_rs1_q <= 1'b0;
            uses_rs2_q <= 1'b0;
            ru_rs1_q   <= '0;
            ru_rs2_q   <= '0;
            imm_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            uses_rs1_q <= uses_rs1_d;
            uses_rs2_q <= uses_rs2_d;
            ru_rs1_q   <= ru_rs1_d;
            ru_rs2_q   <= ru_rs2_d;
            imm_q      <= imm_d;
        end
    end

    assign pc_ex          = pc_q;
    assign pc_plus4_ex    = pc_plus4_q;
    assign rs1_ex         = rs1_q;
    assign rs2_ex         = rs2_q;
    assign rd_ex          = rd_q;
    assign uses_rs1_ex    = uses_rs1_q;
    assign uses_rs2_ex    = uses_rs2_q;
    assign ru_rs1_ex      = ru_rs1_q;
    assign ru_rs2_ex      = ru_rs2_q;
    assign imm_ex         = imm_q;
    assign valid_ex       = valid_q;
    assign RUWr_ex        = ctrl_q.ru_wr;
    assign ALUASrc_ex     = ctrl_q.alu_a_src;
    assign ALUBSrc_ex     = ctrl_q.alu_b_src;
    assign DMWr_ex        = ctrl_q.dm_wr;
    assign ALUOp_ex       = ctrl_q.alu_op;
    assign BrOp_ex        = ctrl_q.br_op;
    assign DMCtrl_ex      = ctrl_q.dm_ctrl;
    assign RUDataWrSrc_ex = ctrl_q.wb_src;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end else if (load_use) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
